// File: rtl/fpm_normalize_round_if.sv
// Handshake bus for the FP multiplier normalize/round stage: product beat in, IEEE-754 result out.
interface fpm_normalize_round_if;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] prod;
   logic [9:0]  exp_sum;
   logic        sign;
   logic        in_nan;
   logic        in_inf;
   logic        in_zero;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;
   logic        inexact;

   modport slave (
      input  in_valid, prod, exp_sum, sign, in_nan, in_inf, in_zero, out_ready,
      output in_ready, out_valid, result, overflow, underflow, inexact
   );

   modport master (
      output in_valid, prod, exp_sum, sign, in_nan, in_inf, in_zero, out_ready,
      input  in_ready, out_valid, result, overflow, underflow, inexact
   );
endinterface

// File: rtl/fpm_normalize_round.sv
// Two-stage normalize + round back end of a single-precision multiplier.
// Define FPM_RNE_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fpm_normalize_round (
   input  logic                  clk,
   input  logic                  rst,
   fpm_normalize_round_if.slave  bus
);

   typedef struct packed {
      logic        sign;
      logic        nan;
      logic        inf;
      logic        zero;
      logic [22:0] mant;
      logic        guard;
      logic        sticky;
      logic [9:0]  exp;
   } norm_t;

   norm_t       n_beat;
   norm_t       s1;
   logic        s1_valid;
   logic        s2_valid;
   logic        s1_load;
   logic        s2_load;

   logic        round_up;
   logic        carry;
   logic [22:0] r_mant;
   logic signed [9:0] r_exp;
   logic [31:0] n_result;
   logic        n_overflow;
   logic        n_underflow;
   logic        n_inexact;

   logic [31:0] result_q;
   logic        overflow_q;
   logic        underflow_q;
   logic        inexact_q;

   assign s2_load      = !s2_valid || bus.out_ready;
   assign s1_load      = !s1_valid || s2_load;
   assign bus.in_ready = s1_load;

   // Stage 1: align the 48-bit product so the hidden bit drops out.
   always_comb begin
      // NOTE: every field gets a default before the branches, so no latch is inferred.
      n_beat        = '0;
      n_beat.sign   = bus.sign;
      n_beat.nan    = bus.in_nan;
      n_beat.inf    = bus.in_inf;
      n_beat.zero   = bus.in_zero;
      if (bus.prod[47]) begin
         n_beat.mant   = bus.prod[46:24];
         n_beat.guard  = bus.prod[23];
         n_beat.sticky = |bus.prod[22:0];
         n_beat.exp    = bus.exp_sum + 10'd1;
      end else begin
         n_beat.mant   = bus.prod[45:23];
         n_beat.guard  = bus.prod[22];
         n_beat.sticky = |bus.prod[21:0];
         n_beat.exp    = bus.exp_sum;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all stages update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          s1_valid <= 1'b0;
      else if (s1_load) s1_valid <= bus.in_valid;
   end

   // NOTE: payload registers carry no reset; s1_valid alone qualifies them.
   always_ff @(posedge clk) begin
      if (s1_load && bus.in_valid) s1 <= n_beat;
   end

   // Stage 2: round, then range-check the exponent.
`ifdef FPM_RNE_ROUND_EN
   assign round_up = s1.guard & (s1.sticky | s1.mant[0]);
`else
   assign round_up = 1'b0;
`endif

   always_comb begin
      {carry, r_mant} = {1'b0, s1.mant} + {23'd0, round_up};
      r_exp           = $signed(s1.exp + {9'd0, carry});
   end

   always_comb begin
      n_result    = {s1.sign, r_exp[7:0], r_mant};
      n_overflow  = 1'b0;
      n_underflow = 1'b0;
      n_inexact   = s1.guard | s1.sticky;
      if (s1.nan) begin
         n_result  = 32'h7FC0_0000;
         n_inexact = 1'b0;
      end else if (s1.inf) begin
         n_result  = {s1.sign, 8'hFF, 23'h0};
         n_inexact = 1'b0;
      end else if (s1.zero) begin
         n_result  = {s1.sign, 31'h0};
         n_inexact = 1'b0;
      end else if (r_exp >= 10'sd255) begin
         n_result   = {s1.sign, 8'hFF, 23'h0};
         n_overflow = 1'b1;
         n_inexact  = 1'b1;
      end else if (r_exp <= 10'sd0) begin
         n_result    = {s1.sign, 31'h0};
         n_underflow = 1'b1;
         n_inexact   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid    <= 1'b0;
         result_q    <= 32'h0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         inexact_q   <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            result_q    <= n_result;
            overflow_q  <= n_overflow;
            underflow_q <= n_underflow;
            inexact_q   <= n_inexact;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.result    = result_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
   assign bus.inexact   = inexact_q;

endmodule

// File: doc/fpm_normalize_round.md
FPM_NORMALIZE_ROUND -- requirements
Module: fpm_normalize_round

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  product beat present.
REQ-004 in_ready  output  1  block accepts beat this cycle.
REQ-005 prod  input  48  unsigned 24x24 mantissa product (hidden bits included), from the pipelined mantissa multiplier.
REQ-006 exp_sum  input  10  two's-complement biased exponent ea+eb-127.
REQ-007 sign  input  1  result sign (sa XOR sb).
REQ-008 in_nan, in_inf, in_zero  input  1 each  special-case flags decoded upstream (inf*0 arrives as in_nan).
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 result  output  32  IEEE-754 single-precision product.
REQ-012 overflow, underflow, inexact  output  1 each  status for the beat on result.

Function
REQ-013 Two-stage pipeline, valid/ready handshake; a beat transfers on in_valid&&in_ready and on out_valid&&out_ready.
REQ-014 Latency is exactly 2 cycles from input transfer to out_valid when out_ready is held high; throughput 1 beat/cycle.
REQ-015 Stage 2 loads when empty or out_ready=1; stage 1 loads when empty or stage 2 loads; in_ready = !s1_valid || s2_load.
REQ-016 Under backpressure, held beats are neither lost, duplicated nor reordered, and their outputs remain stable.
REQ-017 Stage 1 normalize: if prod[47]=1, mant=prod[46:24], guard=prod[23], sticky=OR(prod[22:0]), exp=exp_sum+1; otherwise mant=prod[45:23], guard=prod[22], sticky=OR(prod[21:0]), exp=exp_sum.
REQ-018 Stage 2 round: round_up = guard & (sticky | mant[0]); on carry-out of mant+1, mant=0 and exp+1.
REQ-019 inexact = guard | sticky, for non-special beats only.
REQ-020 Post-round exp >= 255 (signed) -> result {sign,8'hFF,23'h0}, overflow=1, inexact=1.
REQ-021 Post-round exp <= 0 (signed) -> result {sign,31'h0} (flush to zero), underflow=1, inexact=1.
REQ-022 Specials override arithmetic with priority nan > inf > zero: nan -> 32'h7FC00000; inf -> {sign,8'hFF,23'h0}; zero -> {sign,31'h0}; every status flag 0.
REQ-023 Otherwise result = {sign, exp[7:0], mant}.

Reset
REQ-024 While rst is high, both stage valids, out_valid, result and all flags are 0, and in_ready is 1 once rst deasserts.
REQ-025 Reset asserted mid-operation discards every in-flight beat immediately, with no output transfer.

Configuration
REQ-026 Macro FPM_RNE_ROUND_EN defined: rounding per REQ-018 (round-to-nearest-even).
REQ-027 Macro undefined: round_up forced to 0 (truncation); inexact and the REQ-020/REQ-021 checks still apply; latency unchanged.

Verification
REQ-028 prod=48'h900000000000, exp_sum=127, sign=0 -> result 32'h40100000 after 2 cycles, all flags 0.
REQ-029 prod=48'h400000C00000, exp_sum=127 -> with the macro 32'h3F800002, inexact=1; without it 32'h3F800001, inexact=1.
REQ-030 prod=48'h400000400000, exp_sum=127 (tie, LSB even) -> 32'h3F800000, inexact=1, in both configurations.
REQ-031 prod=48'h800000000000, exp_sum=254, sign=1 -> 32'hFF800000, overflow=1. exp_sum=10'h3FF (-1) with prod[47]=0 -> 32'h00000000, underflow=1.
REQ-032 Three back-to-back beats with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted, then all 3 results emerge in order; in_nan=1 with in_inf=1 -> 32'h7FC00000.
REQ-033 Assert rst while 2 beats are in flight -> out_valid=0 in the same cycle; no stale result appears after rst deasserts.
